// File: rtl/mem_module_buffer_pkg.sv
// Shared types and default geometry for the inter-layer feature-map buffer.
package mem_module_buffer_pkg;

    localparam int DEF_NUMBER_OF_K          = 4;
    localparam int DEF_BIT_SIZE             = 32;
    localparam int DEF_PROCESSING_ELEMENTS  = 2;
    localparam int DEF_IMAGE_WIDTH          = 2;

    localparam int PIXELS = DEF_IMAGE_WIDTH * DEF_IMAGE_WIDTH;
    localparam int TOTAL  = DEF_NUMBER_OF_K * PIXELS;
    localparam int GROUPS = DEF_NUMBER_OF_K / DEF_PROCESSING_ELEMENTS;

    typedef logic [DEF_BIT_SIZE-1:0] pixel_t;

    typedef enum logic {
        ST_LOAD = 1'b0,
        ST_DUMP = 1'b1
    } state_t;

    function automatic int index_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/mem_module_buffer_kernel_image_store.sv
// One kernel's output image: a raster-order write counter and a PIXELS-deep
// register array, exposed in full so the top level can mux any word out.
module kernel_image_store
    import mem_module_buffer_pkg::*;
#(
    parameter int BitSize = 32,
    parameter int Pixels  = 4
) (
    input  logic                            clk,
    input  logic                            res_n,
    input  logic                            wr_en,
    input  logic                            clear,
    input  logic [BitSize-1:0]              wr_data,
    output logic                            full,
    output logic                            last_write,
    output logic [Pixels-1:0][BitSize-1:0]  image
);

    localparam int WW = $clog2(Pixels + 1);
    localparam int AW = index_width(Pixels);

    logic [WW-1:0] wcnt;
    logic          accept;

    assign full       = (wcnt == WW'(Pixels));
    assign accept     = wr_en && !full;
    assign last_write = accept && (wcnt == WW'(Pixels - 1));

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            wcnt <= '0;
        end else if (clear) begin
            wcnt <= '0;
        end else if (accept) begin
            wcnt <= wcnt + WW'(1);
        end
    end

    // Storage carries no reset; contents are only read after a full load.
    always_ff @(posedge clk) begin
        if (accept) begin
            image[wcnt[AW-1:0]] <= wr_data;
        end
    end

endmodule

// File: rtl/mem_module_buffer.sv
// Collects NumberOfK kernel images from time-multiplexed PE lanes, then streams
// every stored pixel out serially (kernel-major, raster order) and re-arms.
module mem_module_buffer
    import mem_module_buffer_pkg::*;
#(
    parameter int NumberOfK          = 4,
    parameter int BitSize            = 32,
    parameter int ProcessingElements = 2,
    parameter int ImageWidth         = 2
) (
    input  logic                                        clk,
    input  logic                                        res_n,
    input  logic [NumberOfK-1:0]                        in_valid,
    input  logic [ProcessingElements-1:0][BitSize-1:0]  in_data,
    output logic [BitSize-1:0]                          out_data,
    output logic                                        out_valid,
    output logic                                        image_done,
    output state_t                                      state_dbg
);

    localparam int PIX = ImageWidth * ImageWidth;
    localparam int TOT = NumberOfK * PIX;
    localparam int RW  = index_width(TOT);

    // Handshake: out_valid qualifies out_data for exactly one cycle; there is
    // no ready, the consumer must take every word. in_valid bits are plain
    // strobes with no back-pressure and are ignored outside LOAD.

    state_t                                  state;
    logic [RW-1:0]                           rcnt;
    logic [NumberOfK-1:0]                    full;
    logic [NumberOfK-1:0]                    last_write;
    logic [NumberOfK-1:0][PIX-1:0][BitSize-1:0] images;
    logic [TOT-1:0][BitSize-1:0]             flat;
    logic                                    load_en;
    logic                                    load_done;
    logic                                    dump_last;

    assign load_en   = (state == ST_LOAD);
    assign load_done = load_en && (&(full | last_write));
    assign dump_last = (state == ST_DUMP) && (rcnt == RW'(TOT - 1));
    assign flat      = images;
    assign state_dbg = state;

    for (genvar k = 0; k < NumberOfK; k++) begin : g_store
        kernel_image_store #(
            .BitSize (BitSize),
            .Pixels  (PIX)
        ) u_store (
            .clk        (clk),
            .res_n      (res_n),
            .wr_en      (load_en && in_valid[k]),
            .clear      (dump_last),
            .wr_data    (in_data[k % ProcessingElements]),
            .full       (full[k]),
            .last_write (last_write[k]),
            .image      (images[k])
        );
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state      <= ST_LOAD;
            rcnt       <= '0;
            out_data   <= '0;
            out_valid  <= 1'b0;
            image_done <= 1'b0;
        end else begin
            out_valid  <= 1'b0;
            image_done <= 1'b0;
            case (state)
                ST_LOAD: begin
                    if (load_done) begin
                        state <= ST_DUMP;
                        rcnt  <= '0;
                    end
                end
                ST_DUMP: begin
                    out_data  <= flat[rcnt];
                    out_valid <= 1'b1;
                    rcnt      <= rcnt + RW'(1);
                    // The store counters clear on this same edge via dump_last.
                    if (dump_last) begin
                        image_done <= 1'b1;
                        rcnt       <= '0;
                        state      <= ST_LOAD;
                    end
                end
                default: state <= ST_LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_module_buffer.sv
// Directed scoreboard bench for mem_module_buffer with default geometry
// (4 kernels, 2 lanes, 2x2 images, 32-bit pixels).
module tb_mem_module_buffer;
    import mem_module_buffer_pkg::*;

    logic               clk;
    logic               res_n;
    logic [3:0]         in_valid;
    logic [1:0][31:0]   in_data;
    logic [31:0]        out_data;
    logic               out_valid;
    logic               image_done;
    state_t             state_dbg;

    logic [31:0] exp_q[$];
    logic        exp_last_q[$];
    logic [31:0] cur_set [16];
    bit          start_wait;
    int          n_vec;
    int          n_err;

    localparam logic [31:0] TAB_GROUPED [16] = '{
        32'd1, 32'd1, 32'd1, 32'd1, 32'd2, 32'd2, 32'd2, 32'd2,
        32'd3, 32'd3, 32'd3, 32'd3, 32'd4, 32'd4, 32'd4, 32'd4};
    localparam logic [31:0] TAB_ORDER [16] = '{
        32'd0,  32'd1,  32'd2,  32'd3,  32'd16, 32'd17, 32'd18, 32'd19,
        32'd32, 32'd33, 32'd34, 32'd35, 32'd48, 32'd49, 32'd50, 32'd51};
    localparam logic [31:0] TAB_IDLE [16] = '{
        32'd100, 32'd101, 32'd102, 32'd103, 32'd200, 32'd201, 32'd202, 32'd203,
        32'd300, 32'd301, 32'd302, 32'd303, 32'd400, 32'd401, 32'd402, 32'd403};

    mem_module_buffer #(
        .NumberOfK          (4),
        .BitSize            (32),
        .ProcessingElements (2),
        .ImageWidth         (2)
    ) dut (
        .clk        (clk),
        .res_n      (res_n),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .image_done (image_done),
        .state_dbg  (state_dbg)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Driver tasks
    task automatic drive(input logic [3:0] v, input logic [31:0] l0, input logic [31:0] l1);
        @(negedge clk);
        in_valid   = v;
        in_data[0] = l0;
        in_data[1] = l1;
        @(posedge clk);
        #1;
        in_valid = 4'b0000;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(4'b0000, 32'hdead, 32'hbeef);
    endtask

    task automatic push_set();
        for (int i = 0; i < 16; i++) begin
            exp_q.push_back(cur_set[i]);
            exp_last_q.push_back(i == 15);
        end
        start_wait = 1'b1;
    endtask

    task automatic wait_drain();
        int i;
        for (i = 0; i < 60 && exp_q.size() != 0; i++) @(posedge clk);
        check("drain", exp_q.size(), 0);
        repeat (3) @(posedge clk);
    endtask

    task automatic load_order_set();
        for (int p = 0; p < 4; p++) begin
            drive(4'b0011, p, 16 + p);
            drive(4'b1100, 32 + p, 48 + p);
        end
    endtask

    // Scoreboard monitor: samples on the falling edge
    always @(negedge clk) begin
        if (res_n) begin
            if (start_wait) begin
                check("first_latency_valid", out_valid, 1'b0);
                start_wait = 1'b0;
            end else if (exp_q.size() != 0) begin
                check("word_valid", out_valid, 1'b1);
                if (out_valid) begin
                    check("word_data", out_data, exp_q.pop_front());
                    check("word_done", image_done, exp_last_q.pop_front());
                end
            end else begin
                check("idle_valid", out_valid, 1'b0);
                check("idle_done", image_done, 1'b0);
            end
        end
    end

    initial begin
        n_vec      = 0;
        n_err      = 0;
        start_wait = 1'b0;
        res_n      = 1'b0;
        in_valid   = 4'b0000;
        in_data    = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_out_valid", out_valid, 1'b0);
        check("reset_image_done", image_done, 1'b0);
        check("reset_out_data", out_data, 32'd0);
        check("reset_state", state_dbg, ST_LOAD);
        @(posedge clk);
        #2 res_n = 1'b1;

        // Grouped load: kernels 0/1 then 2/3 each pixel slot
        for (int p = 0; p < 4; p++) begin
            drive(4'b0011, 32'd1, 32'd2);
            drive(4'b1100, 32'd3, 32'd4);
        end
        cur_set = TAB_GROUPED;
        push_set();
        wait_drain();

        // Pixel ordering
        load_order_set();
        cur_set = TAB_ORDER;
        push_set();
        wait_drain();

        // Idle gaps, overflow write to full kernels, single-kernel strobes
        for (int p = 0; p < 4; p++) begin
            drive(4'b0011, 100 + p, 200 + p);
            idle(1);
        end
        drive(4'b0011, 32'd999, 32'd998);
        idle(3);
        for (int p = 0; p < 4; p++) begin
            drive(4'b0100, 300 + p, 32'd777);
            idle(1);
            drive(4'b1000, 32'd666, 400 + p);
        end
        cur_set = TAB_IDLE;
        push_set();
        wait_drain();

        // Back-to-back: reload straight away and expect the new contents
        load_order_set();
        cur_set = TAB_ORDER;
        push_set();
        wait_drain();

        // Asynchronous reset in the middle of a dump
        for (int p = 0; p < 4; p++) begin
            drive(4'b0011, 32'd1, 32'd2);
            drive(4'b1100, 32'd3, 32'd4);
        end
        cur_set = TAB_GROUPED;
        push_set();
        repeat (5) @(posedge clk);
        #2 res_n = 1'b0;
        #1;
        check("async_reset_valid", out_valid, 1'b0);
        check("async_reset_done", image_done, 1'b0);
        check("async_reset_data", out_data, 32'd0);
        check("async_reset_state", state_dbg, ST_LOAD);
        exp_q.delete();
        exp_last_q.delete();
        start_wait = 1'b0;
        @(posedge clk);
        #2 res_n = 1'b1;

        // Partial load, then reset again: partial data must be discarded
        drive(4'b0011, 32'd55, 32'd66);
        drive(4'b0011, 32'd55, 32'd66);
        @(posedge clk);
        #2 res_n = 1'b0;
        @(posedge clk);
        #2 res_n = 1'b1;

        load_order_set();
        cur_set = TAB_ORDER;
        push_set();
        wait_drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
